// File: rtl/line_engine.sv
// Bresenham line rasterizer: takes endpoints and a colour from the core's MMIO
// registers and emits one framebuffer pixel write per accepted handshake.
module line_engine #(
  parameter logic [31:0] FB_BASE = 32'h1000_0000,
  parameter int          CW      = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   line_color,
  input  logic [CW-1:0] line_point,
  input  logic          line_color_valid,
  input  logic          line_x0_valid,
  input  logic          line_y0_valid,
  input  logic          line_x1_valid,
  input  logic          line_y1_valid,
  input  logic          line_trigger,
  output logic          line_ready,
  output logic          px_valid,
  input  logic          px_ready,
  output logic [31:0]   px_addr,
  output logic [23:0]   px_color
);

  localparam int DW = CW + 2;

  typedef enum logic [1:0] {IDLE, SWAP, CALC, DRAW} state_t;

  state_t state, state_nxt;

  // Core-visible registers
  logic [CW-1:0] x0_q, y0_q, x1_q, y1_q;
  logic [23:0]   color_q;

  // Snapshot of the active line; rewritten in place by the SWAP stage
  logic [CW-1:0] sx0, sy0, sx1, sy1;
  logic [23:0]   scolor;
  logic          steep;

  // Walk state
  logic [CW-1:0]        x_cur, y_cur;
  logic signed [DW-1:0] err, dx, dy;
  logic                 y_down;

  // Combinational helpers
  logic signed [DW-1:0] ddx, ddy, adx, ady, err_dec;
  logic                 steep_c;
  logic [CW-1:0]        ax0, ay0, ax1, ay1;
  logic [CW-1:0]        nx0, ny0, nx1, ny1;
  logic [CW-1:0]        pix_x, pix_y;
  logic                 last_px;

  always_comb begin
    ddx     = $signed({2'b00, sx1}) - $signed({2'b00, sx0});
    ddy     = $signed({2'b00, sy1}) - $signed({2'b00, sy0});
    adx     = ddx[DW-1] ? -ddx : ddx;
    ady     = ddy[DW-1] ? -ddy : ddy;
    steep_c = ady > adx;

    ax0 = steep_c ? sy0 : sx0;
    ay0 = steep_c ? sx0 : sy0;
    ax1 = steep_c ? sy1 : sx1;
    ay1 = steep_c ? sx1 : sy1;
    if (ax0 > ax1) begin
      nx0 = ax1; ny0 = ay1; nx1 = ax0; ny1 = ay0;
    end else begin
      nx0 = ax0; ny0 = ay0; nx1 = ax1; ny1 = ay1;
    end

    err_dec = err - dy;
    last_px = (x_cur == sx1);
    pix_x   = steep ? y_cur : x_cur;
    pix_y   = steep ? x_cur : y_cur;
  end

  // NOTE: every variable in an always_comb gets a value on all paths (defaults first), otherwise a latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (line_trigger) state_nxt = SWAP;
      SWAP:    state_nxt = CALC;
      CALC:    state_nxt = DRAW;
      DRAW:    if (px_ready && last_px) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every stage reads pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
      sx0     <= '0;
      sy0     <= '0;
      sx1     <= '0;
      sy1     <= '0;
      scolor  <= '0;
      steep   <= 1'b0;
      x_cur   <= '0;
      y_cur   <= '0;
      err     <= '0;
      dx      <= '0;
      dy      <= '0;
      y_down  <= 1'b0;
    end else begin
      if (line_color_valid) color_q <= line_color[23:0];
      if (line_x0_valid)    x0_q    <= line_point;
      if (line_y0_valid)    y0_q    <= line_point;
      if (line_x1_valid)    x1_q    <= line_point;
      if (line_y1_valid)    y1_q    <= line_point;

      case (state)
        IDLE: if (line_trigger) begin
          sx0    <= x0_q;
          sy0    <= y0_q;
          sx1    <= x1_q;
          sy1    <= y1_q;
          scolor <= color_q;
        end
        SWAP: begin
          steep <= steep_c;
          sx0   <= nx0;
          sy0   <= ny0;
          sx1   <= nx1;
          sy1   <= ny1;
        end
        CALC: begin
          dx     <= ddx;
          dy     <= ady;
          err    <= ddx >>> 1;
          y_down <= !(sy0 < sy1);
          x_cur  <= sx0;
          y_cur  <= sy0;
        end
        DRAW: if (px_ready && !last_px) begin
          x_cur <= x_cur + 1'b1;
          if (err_dec[DW-1]) begin
            y_cur <= y_down ? y_cur - 1'b1 : y_cur + 1'b1;
            err   <= err_dec + dx;
          end else begin
            err   <= err_dec;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs read zero outside DRAW so an idle engine presents a clean bus
  assign line_ready = (state == IDLE);
  assign px_valid   = (state == DRAW);
  assign px_addr    = px_valid ? (FB_BASE | 32'({pix_y, pix_x, 2'b00})) : '0;
  assign px_color   = px_valid ? scolor : '0;

endmodule

// File: tb/tb_line_engine.sv
// Directed bench for line_engine: fixed lines with hand-derived pixel lists,
// backpressure, mid-line writes/triggers, reset abort and single-point latency.
module tb_line_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] line_color;
  logic [9:0]  line_point;
  logic        line_color_valid, line_x0_valid, line_y0_valid;
  logic        line_x1_valid, line_y1_valid, line_trigger;
  logic        line_ready, px_valid, px_ready;
  logic [31:0] px_addr;
  logic [23:0] px_color;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_addr[$];
  logic [23:0] exp_color;
  logic [31:0] got_addr[$];
  logic [23:0] got_color[$];
  int          first_valid;
  int          last_iter;

  always #5 clk = ~clk;

  line_engine dut (
    .clk              (clk),
    .rst              (rst),
    .line_color       (line_color),
    .line_point       (line_point),
    .line_color_valid (line_color_valid),
    .line_x0_valid    (line_x0_valid),
    .line_y0_valid    (line_y0_valid),
    .line_x1_valid    (line_x1_valid),
    .line_y1_valid    (line_y1_valid),
    .line_trigger     (line_trigger),
    .line_ready       (line_ready),
    .px_valid         (px_valid),
    .px_ready         (px_ready),
    .px_addr          (px_addr),
    .px_color         (px_color)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic add_px(input int x, input int y);
    logic [9:0] xs, ys;
    xs = x[9:0];
    ys = y[9:0];
    exp_addr.push_back(32'h1000_0000 | {10'b0, ys, xs, 2'b00});
  endtask

  task automatic wr(input int sel, input logic [31:0] v);
    @(negedge clk);
    line_point = v[9:0];
    line_color = v;
    case (sel)
      0: line_x0_valid    = 1'b1;
      1: line_y0_valid    = 1'b1;
      2: line_x1_valid    = 1'b1;
      3: line_y1_valid    = 1'b1;
      default: line_color_valid = 1'b1;
    endcase
    @(negedge clk);
    line_x0_valid = 1'b0; line_y0_valid = 1'b0; line_x1_valid = 1'b0;
    line_y1_valid = 1'b0; line_color_valid = 1'b0;
  endtask

  task automatic load_line(input int x0, input int y0, input int x1, input int y1,
                           input logic [31:0] col);
    wr(0, x0); wr(1, y0); wr(2, x1); wr(3, y1); wr(4, col);
    exp_addr.delete();
    exp_color = col[23:0];
  endtask

  task automatic trigger(input string tag);
    @(negedge clk);
    line_trigger = 1'b1;
    @(negedge clk);
    line_trigger = 1'b0;
    check({tag, "_busy"}, line_ready, 1'b0);
  endtask

  // One iteration per negedge; px_ready set here applies to the next posedge
  task automatic collect(input string tag, input int stall_at, input int stall_len,
                         input int inject_at, input int reset_at);
    int iter = 0;
    int stalled = 0;
    bit injected = 1'b0;
    got_addr.delete();
    got_color.delete();
    first_valid = -1;
    forever begin
      @(negedge clk);
      iter++;
      line_x1_valid = 1'b0;
      line_trigger  = 1'b0;
      if (iter > 200) begin
        check({tag, "_timeout"}, line_ready, 1'b1);
        break;
      end
      if (line_ready) break;
      if (px_valid && first_valid < 0) first_valid = iter;
      if (reset_at >= 0 && px_valid && got_addr.size() == reset_at) begin
        rst = 1'b1;
        px_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        px_ready = 1'b1;
        check({tag, "_rst_valid"}, px_valid, 1'b0);
        check({tag, "_rst_ready"}, line_ready, 1'b1);
        check({tag, "_rst_addr"}, px_addr, 32'h0);
        check({tag, "_rst_color"}, px_color, 24'h0);
        last_iter = iter;
        return;
      end
      if (inject_at >= 0 && !injected && px_valid && got_addr.size() == inject_at) begin
        line_point    = 10'd9;
        line_x1_valid = 1'b1;
        line_trigger  = 1'b1;
        injected      = 1'b1;
      end
      if (px_valid) begin
        if (got_addr.size() == stall_at && stalled < stall_len) begin
          px_ready = 1'b0;
          stalled++;
          check($sformatf("%s_hold_addr%0d", tag, stalled), px_addr, exp_addr[stall_at]);
          check($sformatf("%s_hold_col%0d", tag, stalled), px_color, exp_color);
        end else begin
          px_ready = 1'b1;
          got_addr.push_back(px_addr);
          got_color.push_back(px_color);
        end
      end else begin
        px_ready = 1'b1;
      end
    end
    last_iter = iter;
  endtask

  task automatic verify(input string tag);
    check({tag, "_count"}, got_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr[i]);
      check($sformatf("%s_col%0d", tag, i), got_color[i], exp_color);
    end
  endtask

  initial begin
    rst = 1'b1;
    line_color = '0; line_point = '0;
    line_color_valid = 1'b0; line_x0_valid = 1'b0; line_y0_valid = 1'b0;
    line_x1_valid = 1'b0; line_y1_valid = 1'b0; line_trigger = 1'b0;
    px_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_ready", line_ready, 1'b1);
    check("reset_valid", px_valid, 1'b0);
    check("reset_addr", px_addr, 32'h0);
    check("reset_color", px_color, 24'h0);
    rst = 1'b0;

    // Horizontal: four pixels on consecutive cycles, then ready
    load_line(0, 0, 3, 0, 32'h00FF_0000);
    for (int k = 0; k < 4; k++) add_px(k, 0);
    trigger("horiz");
    collect("horiz", -1, 0, -1, -1);
    verify("horiz");
    check("horiz_span", last_iter - first_valid, 4);

    // Steep line walks along y
    load_line(5, 2, 6, 6, 32'h0012_3456);
    add_px(5, 2); add_px(5, 3); add_px(5, 4); add_px(6, 5); add_px(6, 6);
    trigger("steep");
    collect("steep", -1, 0, -1, -1);
    verify("steep");

    // Reversed endpoints draw ascending x
    load_line(3, 1, 0, 1, 32'h00AB_CDEF);
    for (int k = 0; k < 4; k++) add_px(k, 1);
    trigger("rev");
    collect("rev", -1, 0, -1, -1);
    verify("rev");

    // Diagonal with a 5-cycle stall at the fourth pixel
    load_line(0, 0, 7, 7, 32'h0000_00FF);
    for (int k = 0; k < 8; k++) add_px(k, k);
    trigger("bp");
    collect("bp", 3, 5, -1, -1);
    verify("bp");

    // Write x1=9 and trigger mid-line: current line unchanged, trigger dropped
    load_line(0, 0, 4, 0, 32'h0000_FF00);
    for (int k = 0; k < 5; k++) add_px(k, 0);
    trigger("mid");
    collect("mid", -1, 0, 1, -1);
    verify("mid");
    repeat (2) @(negedge clk);
    check("mid_no_retrig_ready", line_ready, 1'b1);
    check("mid_no_retrig_valid", px_valid, 1'b0);

    // Next trigger sees x1=9; reset after three pixels aborts it
    exp_addr.delete();
    for (int k = 0; k < 3; k++) add_px(k, 0);
    trigger("x1_9");
    collect("x1_9", -1, 0, -1, 3);
    verify("x1_9");

    // Registers cleared by reset: a bare trigger draws one black pixel at (0,0)
    exp_addr.delete();
    exp_color = 24'h0;
    add_px(0, 0);
    trigger("post_rst");
    collect("post_rst", -1, 0, -1, -1);
    verify("post_rst");

    // Degenerate line: one pixel, first px_valid two edges after trigger
    load_line(4, 4, 4, 4, 32'h00FF_FFFF);
    add_px(4, 4);
    trigger("point");
    collect("point", -1, 0, -1, -1);
    verify("point");
    check("point_latency", first_valid, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/line_engine.md
Name: line_engine

Overview:
- Hardware Bresenham line rasterizer; directly downstream of the RISC-V core's line-engine MMIO outputs.
- The core loads endpoints and colour, then pulses trigger.
- The block emits one framebuffer pixel write per accepted handshake toward the memory arbiter.
- Reports line_ready back to the core, which polls it before the next line.

Parameters:
FB_BASE  32'h1000_0000  framebuffer base address; pixel address = FB_BASE | {y[9:0], x[9:0], 2'b00}
CW  10  coordinate width (bits)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
line_color  in  32  pixel colour; bits [23:0] used
line_point  in  10  coordinate value for the *_valid register writes
line_color_valid  in  1  load colour register
line_x0_valid  in  1  load x0 from line_point
line_y0_valid  in  1  load y0 from line_point
line_x1_valid  in  1  load x1 from line_point
line_y1_valid  in  1  load y1 from line_point
line_trigger  in  1  start drawing the line held in the registers
line_ready  out  1  high only in IDLE
px_valid  out  1  pixel write request
px_ready  in  1  arbiter accepts the pixel
px_addr  out  32  pixel byte address
px_color  out  24  pixel colour

Behaviour:
- Reset: state=IDLE; line_ready=1; px_valid=0; px_addr=0; px_color=0; x0/y0/x1/y1/colour registers=0.
- Reset wins over everything, including mid-line: the line is aborted, no further pixels, px_valid=0 on the next cycle.
- Register writes:
  - Any *_valid high latches its value at the clock edge, in any state.
  - Writes made while drawing do not affect the active line; the active line runs from shadow copies snapshotted at trigger.
  - A write in the same cycle as trigger is not seen by that trigger.
- line_trigger:
  - Accepted only in IDLE; ignored otherwise.
  - Snapshot taken on acceptance: coordinates, colour[23:0].
- States: IDLE -> SWAP -> CALC -> DRAW -> IDLE.
  - SWAP (1 cycle):
    - steep = |y1-y0| > |x1-x0|.
    - If steep, swap x and y of both endpoints.
    - Then, if x0 > x1, swap the endpoints.
  - CALC (1 cycle):
    - dx = x1-x0; dy = |y1-y0|.
    - err = dx>>1, signed 12-bit.
    - ystep = +1 if y0<y1, else -1.
    - x = x0, y = y0.
  - DRAW:
    - px_valid=1.
    - px_addr = FB_BASE | {py, px, 2'b00}, where (px,py) = steep ? (y,x) : (x,y).
    - On px_valid & px_ready:
      - If x == x1, go to IDLE.
      - Else x += 1; err -= dy; if new err < 0 then y += ystep and err += dx.
- Timing:
  - Trigger sampled at edge N: line_ready=0 from edge N.
  - px_valid=1 from edge N+2.
  - After the final accepted pixel at edge M: px_valid=0 and line_ready=1 from edge M.
- Pixel count is exactly max(|dx|,|dy|)+1; a degenerate line (identical endpoints) emits exactly one pixel.
- Backpressure: while px_valid & ~px_ready, px_addr and px_color are held stable and no state advances.
- Throughput: one pixel per cycle when px_ready is held high.
- No clipping: coordinates are used as given, with wrap at CW bits.
- Arithmetic:
  - Differences are computed at CW+2 bits signed.
  - err is 12-bit signed; it cannot overflow for CW=10.

Test Plan:
- Horizontal line: x0=0,y0=0,x1=3,y1=0, colour 0xFF0000, trigger, px_ready=1 -> addrs 0x10000000, 0x10000004, 0x10000008, 0x1000000C on 4 consecutive cycles. px_color=0xFF0000 each cycle. line_ready returns to 1 after the 4th pixel.
- Steep line: (5,2)->(6,6) -> pixels (5,2),(5,3),(5,4),(6,5),(6,6), in that order. (3,2) sample address check: 0x1000200C.
- Reversed line: (3,1)->(0,1) -> pixels x=0,1,2,3 at y=1, ascending. Exactly 4 writes.
- Backpressure, mid-line: px_ready=0 for 5 cycles during line (0,0)->(7,7) -> px_addr/px_color stable throughout the stall. Still exactly 8 pixels (k,k).
- Mid-line events:
  - During drawing, a write of x1=9 plus a trigger -> current line unaffected, trigger ignored.
  - A later trigger from IDLE uses x1=9.
  - rst asserted after the 3rd pixel -> px_valid=0 and line_ready=1 on the next cycle; all registers read 0.
- Single point: (4,4)->(4,4) -> exactly one write at 0x10004010. Trigger-to-first-px_valid latency is 2 edges.
